shared_resource_responder: RTL and testbench

Responder end of the pipeline-to-shared-resource request interface. It accepts one tagged request per cycle from whichever pipeline currently holds the arbiter grant. It processes the request through a LATENCY-deep stall-able pipeline and returns the result to the originating pipeline with a per-requester valid/ready handshake. It sits between the grant-muxed request bus and the two pipeline_top instances, and replaces the fixed-latency shared resource where backpressure and per-requester flush are required.

---
 rtl/shared_resource_responder.sv | 90 +++++++++
 tb/tb_shared_resource_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shared_resource_responder.sv
// Responder for the grant-muxed shared-resource request bus: a LATENCY-deep
// stall-able add pipeline with per-requester result handshake and flush.
module shared_resource_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 3,
  parameter int ADD_CONST  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] resource_input,
  input  logic                  in_valid_1,
  input  logic                  in_valid_2,
  input  logic                  flush_1,
  input  logic                  flush_2,
  input  logic                  out_ready_1,
  input  logic                  out_ready_2,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] resource_output,
  output logic                  out_valid_1,
  output logic                  out_valid_2,
  output logic                  busy,
  output logic                  protocol_err,
  output logic [15:0]           done_count_1,
  output logic [15:0]           done_count_2
);

  localparam logic [DATA_WIDTH-1:0] ADD_K = DATA_WIDTH'(ADD_CONST);

  // tag: 0 = requester 1, 1 = requester 2
  typedef struct packed {
    logic                  valid;
    logic                  tag;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  stage_t stages [LATENCY];
  stage_t nxt    [LATENCY];
  stage_t last;
  logic   fire_1, fire_2, last_flushed, advance, accept;

  assign last         = stages[LATENCY-1];
  assign out_valid_1  = last.valid & ~last.tag & ~flush_1;
  assign out_valid_2  = last.valid &  last.tag & ~flush_2;
  assign fire_1       = out_valid_1 & out_ready_1;
  assign fire_2       = out_valid_2 & out_ready_2;
  // A flushed output slot frees itself, so it must not stall the pipe.
  assign last_flushed = last.valid & (last.tag ? flush_2 : flush_1);
  assign advance      = ~last.valid | fire_1 | fire_2 | last_flushed;
  assign in_ready     = advance;
  assign accept       = advance & (in_valid_1 ^ in_valid_2)
                      & (in_valid_1 ? ~flush_1 : ~flush_2);
  assign resource_output = last.valid ? last.data : '0;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) busy = busy | stages[i].valid;
  end

  always_comb begin
    // NOTE: every element of nxt gets a default first so no latch is inferred.
    for (int i = 0; i < LATENCY; i++) nxt[i] = stages[i];
    if (advance) begin
      for (int i = LATENCY - 1; i > 0; i--) nxt[i] = stages[i-1];
      nxt[0].valid = accept;
      nxt[0].tag   = in_valid_2;
      nxt[0].data  = accept ? resource_input + ADD_K : '0;
    end
    // Flush acts on the post-shift image; other requester's entries keep order.
    for (int i = 0; i < LATENCY; i++) begin
      if (nxt[i].valid && (nxt[i].tag ? flush_2 : flush_1)) nxt[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: stage data is reset too, so the observable state after reset is all-zero.
      for (int i = 0; i < LATENCY; i++) stages[i] <= '0;
      protocol_err <= 1'b0;
      done_count_1 <= '0;
      done_count_2 <= '0;
    end else begin
      // NOTE: non-blocking assignments for all registered state.
      for (int i = 0; i < LATENCY; i++) stages[i] <= nxt[i];
      protocol_err <= protocol_err | (in_valid_1 & in_valid_2);
      if (fire_1) done_count_1 <= done_count_1 + 16'd1;
      if (fire_2) done_count_2 <= done_count_2 + 16'd1;
    end
  end

endmodule

// File: tb/tb_shared_resource_responder.sv
// Self-checking bench for shared_resource_responder: directed scenarios plus a
// randomized phase, all compared against a queue-based behavioural model.
module tb_shared_resource_responder;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int ADD = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] resource_input;
  logic          in_valid_1, in_valid_2, flush_1, flush_2, out_ready_1, out_ready_2;
  logic          in_ready, out_valid_1, out_valid_2, busy, protocol_err;
  logic [DW-1:0] resource_output;
  logic [15:0]   done_count_1, done_count_2;

  shared_resource_responder #(.DATA_WIDTH(DW), .LATENCY(LAT), .ADD_CONST(ADD)) dut (
    .clk(clk), .reset(reset), .resource_input(resource_input),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .flush_1(flush_1), .flush_2(flush_2),
    .out_ready_1(out_ready_1), .out_ready_2(out_ready_2),
    .in_ready(in_ready), .resource_output(resource_output),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .busy(busy), .protocol_err(protocol_err),
    .done_count_1(done_count_1), .done_count_2(done_count_2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queue of in-flight slots, front = newest, back = output slot.
  typedef struct {
    bit          v;
    bit          t;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  bit          m_err;
  logic [15:0] m_cnt1, m_cnt2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t e;
    e.v = 0; e.t = 0; e.d = '0;
    mq.delete();
    for (int i = 0; i < LAT; i++) mq.push_back(e);
    m_err = 0; m_cnt1 = '0; m_cnt2 = '0;
  endtask

  task automatic idle_inputs();
    in_valid_1 = 0; in_valid_2 = 0; flush_1 = 0; flush_2 = 0;
    resource_input = '0; out_ready_1 = 0; out_ready_2 = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic step(input bit iv1, input bit iv2, input logic [31:0] d,
                      input bit f1, input bit f2, input bit r1, input bit r2);
    ent_t last, n;
    bit   ov1, ov2, fire1, fire2, adv, acc;
    @(negedge clk);
    in_valid_1 = iv1; in_valid_2 = iv2; resource_input = d;
    flush_1 = f1; flush_2 = f2; out_ready_1 = r1; out_ready_2 = r2;
    #1;
    last  = mq[LAT-1];
    ov1   = last.v && !last.t && !f1;
    ov2   = last.v &&  last.t && !f2;
    fire1 = ov1 && r1;
    fire2 = ov2 && r2;
    adv   = !last.v || fire1 || fire2 || (last.t ? f2 : f1);
    check("in_ready", in_ready, adv);
    check("out_valid_1", out_valid_1, ov1);
    check("out_valid_2", out_valid_2, ov2);
    check("resource_output", resource_output, last.v ? last.d : 32'h0);
    check("busy", busy, mq[0].v || mq[1].v || mq[2].v);
    check("protocol_err", protocol_err, m_err);
    check("done_count_1", done_count_1, m_cnt1);
    check("done_count_2", done_count_2, m_cnt2);
    @(posedge clk);
    acc = adv && (iv1 != iv2) && (iv1 ? !f1 : !f2);
    if (iv1 && iv2) m_err = 1;
    if (fire1) m_cnt1 = m_cnt1 + 16'd1;
    if (fire2) m_cnt2 = m_cnt2 + 16'd1;
    if (adv) begin
      void'(mq.pop_back());
      n.v = acc; n.t = iv2; n.d = d + 32'(ADD);
      mq.push_front(n);
    end
    foreach (mq[i]) if (mq[i].v && (mq[i].t ? f2 : f1)) mq[i].v = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_data", resource_output, 0);
    @(negedge clk);
    reset = 0;

    // Single request: 5 -> 6 visible right after the third edge.
    step(1, 0, 32'h5, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    #1;
    check("single_ov1", out_valid_1, 1);
    check("single_data", resource_output, 32'h6);
    check("single_ov2", out_valid_2, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    #1;
    check("single_cnt1", done_count_1, 16'd1);
    check("single_ov1_gone", out_valid_1, 0);

    // Alternating stream with carry wrap on the first request.
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 1, 1);
    step(0, 1, 32'h10, 0, 0, 1, 1);
    step(1, 0, 32'h20, 0, 0, 1, 1);
    #1;
    check("alt_wrap_data", resource_output, 32'h0);
    check("alt_wrap_ov1", out_valid_1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1);
    #1;
    check("alt_cnt1", done_count_1, 16'd3);
    check("alt_cnt2", done_count_2, 16'd1);

    // Backpressure from requester 2.
    step(0, 1, 32'h100, 0, 0, 1, 0);
    step(0, 1, 32'h200, 0, 0, 1, 0);
    step(0, 1, 32'h300, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
    #1;
    check("bp_in_ready", in_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_data", resource_output, 32'h101);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1);
    #1;
    check("bp_busy_done", busy, 0);
    check("bp_cnt2", done_count_2, 16'd4);

    // Flush requester 1 with [1:A, 2:B, 1:C] in flight.
    step(1, 0, 32'hA, 0, 0, 0, 0);
    step(0, 1, 32'hB, 0, 0, 0, 0);
    step(1, 0, 32'hC, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1);
    #1;
    check("flush_cnt1", done_count_1, 16'd3);
    check("flush_cnt2", done_count_2, 16'd5);

    // Protocol error.
    step(1, 1, 32'h55, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1);
    #1;
    check("perr_sticky", protocol_err, 1);
    check("perr_busy", busy, 0);

    // Asynchronous reset with two entries in flight.
    step(1, 0, 32'h7, 0, 0, 1, 1);
    step(0, 1, 32'h8, 0, 0, 1, 1);
    @(negedge clk);
    idle_inputs();
    #2 reset = 1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_ov1", out_valid_1, 0);
    check("arst_ov2", out_valid_2, 0);
    check("arst_busy", busy, 0);
    check("arst_perr", protocol_err, 0);
    check("arst_cnt1", done_count_1, 0);
    check("arst_data", resource_output, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 19);
      step(sel inside {[4:10]}, sel inside {[11:18]} || sel == 19 && i > 300,
           $urandom(), $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
